// File: rtl/csr_exec_unit.sv
// csr_exec_unit
// Multi-cycle executor for Zicsr instructions (CSRRW/CSRRS/CSRRC and the
// immediate forms). It serialises CSR access: one instruction is in flight
// at a time, and the pipeline stalls on in_ready.
//
// Ports
//   clk, reset              : clock (rising edge), async active-high reset
//   in_valid/in_ready       : instruction handshake (ready only in IDLE)
//   in_funct3, in_csr_addr  : decoded Zicsr fields
//   in_rs1_idx, in_rs1_data : rs1 index (zimm for imm forms) and rs1 value
//   in_rd, in_pc            : destination register, instruction PC
//   kill                    : flush from older instruction (honoured in READ)
//   csr_addr_read/csr_rdata : combinational read port of the CSR file
//   csr_addr_write/csr_wdata/csr_we : single-cycle write port
//   isCSRRC                 : tied 0; the full new value is always computed
//   out_valid/out_ready     : response handshake to writeback
//   out_rd, out_data        : destination register and old CSR value
//   out_illegal             : funct3 000/100, no write performed
//   redirect_valid/_pc      : refetch pulse at pc+4 on a legal handshake
module csr_exec_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_funct3,
   input  logic [11:0] in_csr_addr,
   input  logic [4:0]  in_rs1_idx,
   input  logic [63:0] in_rs1_data,
   input  logic [4:0]  in_rd,
   input  logic [63:0] in_pc,
   input  logic        kill,
   output logic [11:0] csr_addr_read,
   input  logic [63:0] csr_rdata,
   output logic [11:0] csr_addr_write,
   output logic [63:0] csr_wdata,
   output logic        csr_we,
   output logic        isCSRRC,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_rd,
   output logic [63:0] out_data,
   output logic        out_illegal,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  funct3_q;
   logic [11:0] addr_q;
   logic [4:0]  rs1_idx_q;
   logic [63:0] rs1_data_q;
   logic [4:0]  rd_q;
   logic [63:0] pc_q;
   logic [63:0] old_q;

   logic        illegal;
   logic        write_req;
   logic [63:0] src;
   logic [63:0] new_val;

   // funct3[1:0]==00 covers both illegal encodings (000 and 100).
   assign illegal = (funct3_q[1:0] == 2'b00);
   assign src     = funct3_q[2] ? {59'd0, rs1_idx_q} : rs1_data_q;

   // RW forms always write; set/clear forms only with a non-zero source index.
   assign write_req = !illegal && ((funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0));

   always_comb begin
      new_val = old_q;
      case (funct3_q[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_q | src;
         2'b11:   new_val = old_q & ~src;
         default: new_val = old_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         funct3_q   <= '0;
         addr_q     <= '0;
         rs1_idx_q  <= '0;
         rs1_data_q <= '0;
         rd_q       <= '0;
         pc_q       <= '0;
         old_q      <= '0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            funct3_q   <= in_funct3;
            addr_q     <= in_csr_addr;
            rs1_idx_q  <= in_rs1_idx;
            rs1_data_q <= in_rs1_data;
            rd_q       <= in_rd;
            pc_q       <= in_pc;
         end
         // Snapshot taken once; later CSR-file activity cannot alter out_data.
         if (state_q == READ) begin
            old_q <= csr_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = READ;
         READ: begin
            if (kill)           state_d = IDLE;
            else if (write_req) state_d = WRITE;
            else                state_d = RESP;
         end
         WRITE:   state_d = RESP;
         RESP:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready       = (state_q == IDLE);
      csr_addr_read  = (state_q != IDLE) ? addr_q : '0;
      csr_addr_write = (state_q != IDLE) ? addr_q : '0;
      csr_we         = (state_q == WRITE);
      csr_wdata      = (state_q == WRITE) ? new_val : '0;
      isCSRRC        = 1'b0;
      out_valid      = (state_q == RESP);
      out_rd         = (state_q == RESP) ? rd_q : '0;
      out_data       = (state_q == RESP) ? old_q : '0;
      out_illegal    = (state_q == RESP) && illegal;
      redirect_valid = (state_q == RESP) && out_ready && !illegal;
      redirect_pc    = (state_q == RESP) ? (pc_q + 64'd4) : '0;
   end

endmodule

// File: tb/tb_csr_exec_unit.sv
module tb_csr_exec_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [11:0] in_csr_addr;
   logic [4:0]  in_rs1_idx;
   logic [63:0] in_rs1_data;
   logic [4:0]  in_rd;
   logic [63:0] in_pc;
   logic        kill;
   logic [11:0] csr_addr_read;
   logic [63:0] csr_rdata;
   logic [11:0] csr_addr_write;
   logic [63:0] csr_wdata;
   logic        csr_we;
   logic        isCSRRC;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [63:0] out_data;
   logic        out_illegal;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   csr_exec_unit dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_funct3      (in_funct3),
      .in_csr_addr    (in_csr_addr),
      .in_rs1_idx     (in_rs1_idx),
      .in_rs1_data    (in_rs1_data),
      .in_rd          (in_rd),
      .in_pc          (in_pc),
      .kill           (kill),
      .csr_addr_read  (csr_addr_read),
      .csr_rdata      (csr_rdata),
      .csr_addr_write (csr_addr_write),
      .csr_wdata      (csr_wdata),
      .csr_we         (csr_we),
      .isCSRRC        (isCSRRC),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rd         (out_rd),
      .out_data       (out_data),
      .out_illegal    (out_illegal),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Reference CSR file: the model owns the contents, the DUT only reads it.
   logic [63:0] ref_mem [4096];
   assign csr_rdata = ref_mem[csr_addr_read];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   int unsigned we_cnt = 0;
   logic [11:0] w_addr;
   logic [63:0] w_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (csr_we === 1'b1) begin
         we_cnt <= we_cnt + 1;
         w_addr <= csr_addr_write;
         w_data <= csr_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One complete transaction, expected results derived from the Zicsr rules.
   task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] idx, input logic [63:0] data,
                          input logic [4:0] rd, input logic [63:0] pc,
                          input int unsigned hold, input bit kill_idle,
                          input bit kill_read, input bit kill_resp);
      logic [63:0] old_e, new_e, src;
      int unsigned op, we0, lat;
      bit legal, wr, stable, quiet;
      old_e = ref_mem[addr];
      op    = int'(f3) % 4;
      legal = (op != 0);
      src   = (f3 >= 3'd4) ? 64'(idx) : data;
      wr    = legal && (op == 1 || idx != 5'd0);
      case (op)
         1:       new_e = src;
         2:       new_e = old_e | src;
         3:       new_e = old_e & ~src;
         default: new_e = old_e;
      endcase

      check_eq("in_ready_idle", 64'(in_ready), 64'd1);
      we0         = we_cnt;
      in_valid    = 1'b1;
      in_funct3   = f3;
      in_csr_addr = addr;
      in_rs1_idx  = idx;
      in_rs1_data = data;
      in_rd       = rd;
      in_pc       = pc;
      kill        = kill_idle;
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
      kill        = 1'b0;
      in_funct3   = 3'($urandom);
      in_csr_addr = 12'($urandom);
      in_rs1_idx  = 5'($urandom);
      in_rs1_data = {$urandom, $urandom};
      in_rd       = 5'($urandom);
      in_pc       = {$urandom, $urandom};

      if (kill_read) begin
         kill = 1'b1;
         @(negedge clk);
         kill = 1'b0;
         check_eq("kill_read_in_ready", 64'(in_ready), 64'd1);
         quiet = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
         end
         check_eq("kill_read_no_resp", 64'(quiet), 64'd1);
         check_eq("kill_read_no_write", 64'(we_cnt - we0), 64'd0);
         return;
      end

      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", 64'(lat), wr ? 64'd3 : 64'd2);
      check_eq("write_count", 64'(we_cnt - we0), 64'(wr));
      if (wr) begin
         check_eq("write_addr", 64'(w_addr), 64'(addr));
         check_eq("write_data", w_data, new_e);
      end
      check_eq("out_data", out_data, old_e);
      check_eq("out_rd", 64'(out_rd), 64'(rd));
      check_eq("out_illegal", 64'(out_illegal), 64'(!legal));

      stable = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
         kill = kill_resp;
         if (out_valid !== 1'b1 || out_data !== old_e || out_rd !== rd ||
             in_ready !== 1'b0 || redirect_valid !== 1'b0 || csr_we !== 1'b0)
            stable = 1'b0;
         @(negedge clk);
      end
      if (hold > 0) check_eq("hold_stable", 64'(stable), 64'd1);

      kill      = kill_resp;
      out_ready = 1'b1;
      #1;
      check_eq("redirect_valid", 64'(redirect_valid), 64'(legal));
      check_eq("redirect_pc", redirect_pc, pc + 64'd4);
      @(negedge clk);
      out_ready = 1'b0;
      kill      = 1'b0;
      check_eq("post_out_valid", 64'(out_valid), 64'd0);
      check_eq("post_redirect", 64'(redirect_valid), 64'd0);
      check_eq("post_in_ready", 64'(in_ready), 64'd1);
      if (wr) ref_mem[addr] = new_e;
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_funct3   = '0;
      in_csr_addr = '0;
      in_rs1_idx  = '0;
      in_rs1_data = '0;
      in_rd       = '0;
      in_pc       = '0;
      kill        = 1'b0;
      out_ready   = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = {$urandom, $urandom};

      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_csr_we", 64'(csr_we), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_redirect", 64'(redirect_valid), 64'd0);
      check_eq("rst_illegal", 64'(out_illegal), 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);
      check_eq("rst_addr_read", 64'(csr_addr_read), 64'd0);
      check_eq("rst_wdata", csr_wdata, 64'd0);
      check_eq("rst_isCSRRC", 64'(isCSRRC), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // CSRRW mscratch
      ref_mem[12'h340] = 64'h5;
      run_txn(3'b001, 12'h340, 5'd7, 64'hDEAD_BEEF, 5'd3, 64'h8000_0000, 0, 0, 0, 0);
      // CSRRS / CSRRC mie with rs1 index 0: read only
      ref_mem[12'h304] = 64'hAAA;
      run_txn(3'b010, 12'h304, 5'd0, 64'hFFFF, 5'd4, 64'h100, 0, 0, 0, 0);
      run_txn(3'b011, 12'h304, 5'd0, 64'hFFFF, 5'd5, 64'h104, 0, 0, 0, 0);
      // CSRRCI mstatus, CSRRSI on a zero CSR
      ref_mem[12'h300] = 64'h1888;
      run_txn(3'b111, 12'h300, 5'h08, 64'hFFFF_FFFF, 5'd6, 64'h200, 0, 0, 0, 0);
      ref_mem[12'h341] = 64'h0;
      run_txn(3'b110, 12'h341, 5'h1F, 64'h0, 5'd7, 64'h204, 0, 0, 0, 0);
      // kill in READ, then kill during RESP
      run_txn(3'b001, 12'h340, 5'd1, 64'h1234, 5'd8, 64'h300, 0, 0, 1, 0);
      run_txn(3'b001, 12'h340, 5'd1, 64'h5678, 5'd9, 64'h304, 2, 0, 0, 1);
      // backpressure, illegal encodings, PC wrap, kill in IDLE
      run_txn(3'b010, 12'h305, 5'd3, 64'h0F, 5'd10, 64'h400, 5, 0, 0, 0);
      run_txn(3'b100, 12'h305, 5'd3, 64'h0F, 5'd11, 64'h404, 1, 0, 0, 0);
      run_txn(3'b000, 12'h305, 5'd0, 64'h0F, 5'd12, 64'h408, 0, 0, 0, 0);
      run_txn(3'b101, 12'h305, 5'd0, 64'h0F, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0);
      run_txn(3'b001, 12'h306, 5'd2, 64'hCAFE, 5'd14, 64'h500, 0, 1, 0, 0);

      // Asynchronous reset during WRITE
      in_valid    = 1'b1;
      in_funct3   = 3'b001;
      in_csr_addr = 12'h305;
      in_rs1_idx  = 5'd1;
      in_rs1_data = 64'h9999;
      in_rd       = 5'd1;
      in_pc       = 64'h600;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("write_state_we", 64'(csr_we), 64'd1);
      reset = 1'b1;
      #1;
      check_eq("async_rst_we", 64'(csr_we), 64'd0);
      check_eq("async_rst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("after_rst_valid", 64'(out_valid), 64'd0);
      run_txn(3'b001, 12'h305, 5'd2, 64'h8000_0100, 5'd2, 64'h700, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic [11:0] a;
         logic [4:0]  idx;
         a   = 12'h340 + 12'($urandom_range(0, 7));
         idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         run_txn(3'($urandom), a, idx, {$urandom, $urandom}, 5'($urandom),
                 {$urandom, $urandom}, $urandom_range(0, 3),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Multi-cycle execution unit for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms), sitting directly upstream of the CSR register file in the pipeline's execute stage. It accepts one decoded CSR instruction at a time and reads the old CSR value. It computes the new value, issues a single write pulse to the register file, then returns the old value plus a pipeline redirect to writeback. The unit serialises CSR access: the pipeline stalls on `in_ready` while an instruction is in flight.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: CSR instruction offered.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `in_funct3` in 3: Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- `in_csr_addr` in 12: target CSR address.
- `in_rs1_idx` in 5: rs1 index, or zimm for immediate forms.
- `in_rs1_data` in 64: rs1 register value.
- `in_rd` in 5: destination register.
- `in_pc` in 64: instruction PC.
- `kill` in 1: pipeline flush from an older instruction.
- `csr_addr_read` out 12: read address to the register file.
- `csr_rdata` in 64: combinational read data from the register file.
- `csr_addr_write` out 12: write address.
- `csr_wdata` out 64: full new CSR value.
- `csr_we` out 1: one-cycle write strobe.
- `isCSRRC` out 1: tied 0; the full value is always computed here.
- `out_valid` out 1: result available.
- `out_ready` in 1: writeback accepts the result.
- `out_rd` out 5: destination register.
- `out_data` out 64: old CSR value, zero-extended.
- `out_illegal` out 1: funct3 was 000 or 100; no write performed.
- `redirect_valid` out 1: refetch request, one-cycle pulse.
- `redirect_pc` out 64: `in_pc + 4`, wraps modulo 2^64.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `in_ready`=1. On `in_valid`, latch funct3, address, rs1_idx, rs1_data, rd and pc, then go to READ.
- READ:
  - Drive `csr_addr_read` = latched address and capture `csr_rdata` into `old`.
  - Go to WRITE if a write is required, otherwise go to RESP.
- Source operand:
  - funct3[2]=0: src = rs1_data.
  - funct3[2]=1: src = zero-extended 5-bit rs1_idx.
- New value:
  - RW/RWI: src.
  - RS/RSI: old | src.
  - RC/RCI: old & ~src.
- Write required:
  - RW/RWI: always, including rd=0.
  - RS/RC forms: only if rs1_idx≠0.
  - Illegal funct3: never.
- WRITE: assert `csr_we`=1 for exactly this cycle with `csr_addr_write`/`csr_wdata`, then go to RESP.
- RESP:
  - Hold `out_valid`=1 with stable `out_rd`/`out_data`/`out_illegal` until `out_ready`, then return to IDLE.
  - `redirect_valid` pulses on the handshake cycle, except when `out_illegal`=1.
- `kill` in READ: abort to IDLE, no write, no response.
- `kill` in WRITE or RESP: ignored; the write is architectural once issued. `kill` in IDLE has no effect; the same-cycle `in_valid` is still accepted.
- `csr_addr_read`/`csr_addr_write` hold the latched address outside IDLE, and 0 in IDLE.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `csr_we`=0, `out_valid`=0, `redirect_valid`=0, `out_illegal`=0; all data outputs 0; `isCSRRC`=0.
- Reset asserted mid-operation: return to IDLE immediately, drop `csr_we` asynchronously, discard the instruction.
- Latency with a write: accept at edge 0, READ, WRITE, RESP with `out_valid` at edge 3. Minimum occupancy is 3 cycles, 4 if `out_ready` is low once.
- Latency without a write (RS/RC with src index 0, or illegal): `out_valid` at edge 2.
- `old` is sampled in READ. A concurrent mcycle increment in the register file does not change `out_data`.
- Back-to-back instructions: the next accept is in the cycle after the RESP handshake. There is no overlap.

## Test plan
- CSRRW mscratch (0x340), rs1_data=0xDEAD_BEEF, old 0x5:
  - Exactly one `csr_we` pulse, wdata 0xDEADBEEF.
  - `out_data`=0x5.
  - `redirect_pc`=pc+4.
  - `out_valid` 3 cycles after accept.
- CSRRS mie, rs1_idx=0: `csr_we` never asserts, `out_data`=current mie, response 2 cycles after accept. Repeat with CSRRC, rs1_idx=0: same result.
- CSRRCI mstatus old 0x1888, zimm=0x8: wdata=0x1880. Then CSRRSI zimm=0x1F on old 0x0: wdata=0x1F.
- `kill` asserted in READ: no `csr_we`, no `out_valid`, `in_ready`=1 next cycle. `kill` asserted in RESP: response still delivered.
- Hold `out_ready`=0 for 5 cycles: outputs stable, `in_ready`=0, a single `redirect_valid` pulse on the handshake. Illegal funct3=100: `out_illegal`=1, no write, no redirect.
- Assert `reset` asynchronously during WRITE: `csr_we` falls before the next edge. After reset, CSRRW mtvec works normally.
